// File: rtl/writeback_stage.sv
`timescale 1ns/1ps
// Writeback stage: picks UP / ALU / RET_ADDR / LOAD into a one-entry valid/ready
// output slot. Loads park in WAIT_LOAD until mem_rvalid, then get extended here.
module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int RET_ADDR_W = XLEN - 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            wb_sel,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       upper_immediate,
  input  logic [XLEN-1:0]       alu_out,
  input  logic [RET_ADDR_W-1:0] return_addr,
  input  logic [2:0]            load_funct3,
  input  logic [1:0]            load_offset,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  busy
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [1:0] SEL_UP   = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  state_t                  state_reg;
  logic                    out_valid_reg;
  logic [XLEN-1:0]         wb_data_reg;
  logic [REG_ADDR_W-1:0]   wb_rd_reg;
  logic [REG_ADDR_W-1:0]   load_rd_reg;
  logic [2:0]              funct3_reg;
  logic [1:0]              offset_reg;

  logic                    accept;
  logic [XLEN-1:0]         sel_data;
  logic [XLEN-1:0]         load_data;
  logic [31:0]             word;
  logic [7:0]              lbyte;
  logic [15:0]             lhalf;

  assign in_ready  = clk_enable && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign wb_data   = wb_data_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_we     = out_valid_reg && (wb_rd_reg != '0);
  assign busy      = (state_reg == WAIT_LOAD);

  always_comb begin
    case (wb_sel)
      SEL_UP:  sel_data = upper_immediate;
      SEL_ALU: sel_data = alu_out;
      default: sel_data = XLEN'({return_addr, 2'b00});
    endcase
  end

  // Extraction always works on the low word; only LD on a 64-bit datapath uses the full beat.
  always_comb begin
    word  = mem_rdata[31:0];
    lbyte = word[{offset_reg, 3'b000} +: 8];
    lhalf = offset_reg[1] ? word[31:16] : word[15:0];
    case (funct3_reg)
      3'b000:  load_data = XLEN'($signed(lbyte));
      3'b100:  load_data = XLEN'(lbyte);
      3'b001:  load_data = XLEN'($signed(lhalf));
      3'b101:  load_data = XLEN'(lhalf);
      3'b010:  load_data = XLEN'($signed(word));
      3'b110:  load_data = XLEN'(word);
      3'b011:  load_data = (XLEN == 64) ? mem_rdata : XLEN'($signed(word));
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      wb_data_reg   <= '0;
      wb_rd_reg     <= '0;
      load_rd_reg   <= '0;
      funct3_reg    <= '0;
      offset_reg    <= '0;
    end else if (clk_enable) begin
      if (out_valid_reg && out_ready)
        out_valid_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (accept) begin
          if (wb_sel == SEL_LOAD) begin
            state_reg   <= WAIT_LOAD;
            funct3_reg  <= load_funct3;
            offset_reg  <= load_offset;
            load_rd_reg <= in_rd;
          end else begin
            out_valid_reg <= 1'b1;
            wb_data_reg   <= sel_data;
            wb_rd_reg     <= in_rd;
          end
        end
      end else if (mem_rvalid) begin
        // The slot was drained when the load was accepted, so it is free here.
        out_valid_reg <= 1'b1;
        wb_data_reg   <= load_data;
        wb_rd_reg     <= load_rd_reg;
        state_reg     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
`timescale 1ns/1ps
// Bench for writeback_stage: directed scenarios followed by a randomized run
// checked against a transaction-level model of the slot and pending load.
module tb_writeback_stage;
  localparam int XLEN = 32;
  localparam int RAW  = XLEN - 2;
  localparam int RW   = 5;

  logic            clk, rst, clk_enable, in_valid, in_ready;
  logic [1:0]      wb_sel;
  logic [RW-1:0]   in_rd, wb_rd;
  logic [XLEN-1:0] upper_immediate, alu_out, mem_rdata, wb_data;
  logic [RAW-1:0]  return_addr;
  logic [2:0]      load_funct3;
  logic [1:0]      load_offset;
  logic            mem_rvalid, out_valid, out_ready, wb_we, busy;

  int tests_run = 0;
  int tests_failed = 0;

  writeback_stage #(.XLEN(XLEN), .RET_ADDR_W(RAW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .in_rd(in_rd), .upper_immediate(upper_immediate), .alu_out(alu_out),
    .return_addr(return_addr), .load_funct3(load_funct3), .load_offset(load_offset),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Load semantics from the ISA description, using shifts and masks on the word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    longint b, h, v;
    b = (longint'(w) >> (8 * off)) & 64'hFF;
    h = (longint'(w) >> (16 * (off / 2))) & 64'hFFFF;
    case (f3)
      3'd0:    v = (b >= 128) ? b - 256 : b;
      3'd4:    v = b;
      3'd1:    v = (h >= 32768) ? h - 65536 : h;
      3'd5:    v = h;
      3'd2, 3'd3, 3'd6: v = longint'(w);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_src(input logic [1:0] sel, input logic [31:0] ui,
                                          input logic [31:0] alu, input logic [29:0] ra);
    if (sel == 2'd0) return ui;
    if (sel == 2'd1) return alu;
    return 32'(longint'(ra) * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; wb_sel = 0; in_rd = 0; upper_immediate = 0; alu_out = 0; return_addr = 0;
    load_funct3 = 0; load_offset = 0; mem_rdata = 0; mem_rvalid = 0; out_ready = 1; clk_enable = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    tests_run++; if (wb_data !== 32'h0) begin tests_failed++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    tests_run++; if (wb_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
    tests_run++; if (wb_we !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_we_busy got %b%b want 00", wb_we, busy); end
    rst = 0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    $display("[TB] reset checked");
  endtask

  task automatic test_alu();
    in_valid = 1; wb_sel = 2'd1; alu_out = 32'h12345678; in_rd = 5; out_ready = 1;
    tick();
    in_valid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'h12345678) begin tests_failed++; $display("FAIL alu_data got v=%0h %h want v=1 12345678", out_valid, wb_data); end
    tests_run++; if (wb_rd !== 5'd5 || wb_we !== 1'b1) begin tests_failed++; $display("FAIL alu_rd got rd=%0d we=%0h want rd=5 we=1", wb_rd, wb_we); end
    $display("[TB] ALU rd=5 -> %h", wb_data);
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL alu_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_ret_up();
    in_valid = 1; wb_sel = 2'd2; return_addr = 30'h401; in_rd = 1;
    tick();
    tests_run++; if (wb_data !== 32'h00001004) begin tests_failed++; $display("FAIL ret_addr got %h want 00001004", wb_data); end
    $display("[TB] RET_ADDR 0x401 -> %h", wb_data);
    wb_sel = 2'd0; upper_immediate = 32'hABCDE000; in_rd = 2;
    tick();
    in_valid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'hABCDE000 || wb_rd !== 5'd2) begin tests_failed++; $display("FAIL upper_imm got v=%0h %h rd=%0d want v=1 abcde000 rd=2", out_valid, wb_data, wb_rd); end
    $display("[TB] UP -> %h", wb_data);
    tick();
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] exp;
    exp = ref_load(f3, off, rdata);
    in_valid = 1; wb_sel = 2'd3; load_funct3 = f3; load_offset = off; in_rd = 7;
    mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    in_valid = 0; mem_rvalid = 0; load_funct3 = 0; load_offset = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL load_wait[%0d] got busy=%0h rdy=%0h v=%0h want 1 0 0", i, busy, in_ready, out_valid); end
      if (i == 2) begin mem_rvalid = 1; mem_rdata = rdata; end
      tick();
    end
    mem_rvalid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== exp || wb_rd !== 5'd7 || busy !== 1'b0) begin tests_failed++; $display("FAIL load_f3_%0d got v=%0h %h rd=%0d busy=%0h want v=1 %h rd=7 busy=0", f3, out_valid, wb_data, wb_rd, busy, exp); end
    $display("[TB] LOAD f3=%0d off=%0d rdata=%h -> %h", f3, off, rdata, wb_data);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; wb_sel = 2'd1; alu_out = 32'h55; in_rd = 9;
    tick();
    alu_out = 32'h66; in_rd = 10;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready got %0h want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd9) begin tests_failed++; $display("FAIL bp_hold[%0d] got v=%0h %h rd=%0d want v=1 55 rd=9", i, out_valid, wb_data, wb_rd); end
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'h66 || wb_rd !== 5'd10) begin tests_failed++; $display("FAIL bp_refill got v=%0h %h rd=%0d want v=1 66 rd=10", out_valid, wb_data, wb_rd); end
    $display("[TB] backpressure released -> %h", wb_data);
    tick();
  endtask

  task automatic test_ce_wait();
    in_valid = 1; wb_sel = 2'd3; load_funct3 = 3'd2; load_offset = 0; in_rd = 4;
    tick();
    in_valid = 0; clk_enable = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL ce_in_ready got %0h want 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (out_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL ce_frozen[%0d] got v=%0h busy=%0h want 0 1", i, out_valid, busy); end
    end
    clk_enable = 1;
    tick();
    mem_rvalid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || busy !== 1'b0) begin tests_failed++; $display("FAIL ce_resume got v=%0h %h busy=%0h want v=1 deadbeef busy=0", out_valid, wb_data, busy); end
    $display("[TB] LW after stall -> %h", wb_data);
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1; wb_sel = 2'd1; alu_out = 32'h111; in_rd = 0; out_ready = 1;
    tick();
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'h111 || wb_we !== 1'b0) begin tests_failed++; $display("FAIL b2b_first got v=%0h %h we=%0h want v=1 111 we=0", out_valid, wb_data, wb_we); end
    alu_out = 32'h222; in_rd = 3;
    tick();
    in_valid = 0;
    tests_run++; if (out_valid !== 1'b1 || wb_data !== 32'h222 || wb_we !== 1'b1 || wb_rd !== 5'd3) begin tests_failed++; $display("FAIL b2b_second got v=%0h %h we=%0h rd=%0d want v=1 222 we=1 rd=3", out_valid, wb_data, wb_we, wb_rd); end
    $display("[TB] back-to-back rd=0 then rd=3 -> %h", wb_data);
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_reset_wait();
    in_valid = 1; wb_sel = 2'd3; load_funct3 = 3'd0; in_rd = 6;
    tick();
    in_valid = 0;
    tick();
    #2 rst = 1;
    #1;
    tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_wait got v=%0h busy=%0h want 0 0", out_valid, busy); end
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'hFF;
    tick();
    mem_rvalid = 0;
    tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_dropped got v=%0h busy=%0h want 0 0", out_valid, busy); end
    $display("[TB] reset during WAIT_LOAD dropped the load");
  endtask

  task automatic test_random();
    bit          m_full = 0, m_pend = 0, exp_ready;
    logic [31:0] m_data = 0;
    logic [4:0]  m_rd = 0, m_lrd = 0;
    logic [2:0]  m_f3 = 0;
    logic [1:0]  m_off = 0;
    int          n_out = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom); wb_sel = 2'($urandom); in_rd = 5'($urandom);
      upper_immediate = $urandom; alu_out = $urandom; return_addr = 30'($urandom);
      load_funct3 = 3'($urandom); load_offset = 2'($urandom); mem_rdata = $urandom;
      mem_rvalid = ($urandom % 3) == 0; out_ready = ($urandom % 4) != 0;
      clk_enable = ($urandom % 8) != 0;
      #1;
      exp_ready = clk_enable && !m_pend && (!m_full || out_ready);
      tests_run++; if (in_ready !== exp_ready) begin tests_failed++; $display("FAIL rand_in_ready[%0d] got %0h want %0h", c, in_ready, exp_ready); end
      if (clk_enable) begin
        if (m_full && out_ready) m_full = 0;
        if (in_valid && exp_ready) begin
          if (wb_sel != 2'd3) begin
            m_full = 1; m_data = ref_src(wb_sel, upper_immediate, alu_out, return_addr); m_rd = in_rd;
          end else begin
            m_pend = 1; m_f3 = load_funct3; m_off = load_offset; m_lrd = in_rd;
          end
        end else if (m_pend && mem_rvalid) begin
          m_full = 1; m_pend = 0; m_data = ref_load(m_f3, m_off, mem_rdata); m_rd = m_lrd;
        end
      end
      tick();
      tests_run++; if (out_valid !== m_full || busy !== m_pend) begin tests_failed++; $display("FAIL rand_state[%0d] got v=%0h busy=%0h want %0h %0h", c, out_valid, busy, m_full, m_pend); end
      if (m_full) begin
        tests_run++; if (wb_data !== m_data || wb_rd !== m_rd || wb_we !== (m_rd != 0)) begin tests_failed++; $display("FAIL rand_slot[%0d] got %h rd=%0d we=%0h want %h rd=%0d", c, wb_data, wb_rd, wb_we, m_data, m_rd); end
        n_out++;
      end
    end
    idle_inputs();
    $display("[TB] random run: %0d cycles with a full slot", n_out);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ret_up();
    test_load(3'b000, 2'd2, 32'h00800000);
    test_load(3'b100, 2'd2, 32'h00800000);
    test_load(3'b001, 2'd2, 32'h80010000);
    test_load(3'b101, 2'd2, 32'h80010000);
    test_load(3'b111, 2'd1, 32'hFFFFFFFF);
    test_backpressure();
    test_ce_wait();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
